// File: rtl/serial_deserializer_pkg.sv
// Shared types and defaults for the single-wire serial link receiver.
package serial_deserializer_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 434;
  localparam int unsigned DEF_DATA_BITS    = 8;
  localparam int unsigned DEF_CNT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/serial_deserializer_bit_timer.sv
// Bit-period counter: terminal count at half or full period, restarts itself on terminal count.
module serial_deserializer_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic half,
  output logic tc_c
);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tc_c = (cnt == (half ? HALF_TC : FULL_TC));

  always_ff @(posedge clk) begin
    if (reset || clear || tc_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// 8N1-style serial receiver: synchronises rx, frames LSB-first words and hands them off with valid/ack.
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 all_ones,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  logic                 rx_meta;
  logic                 rx_s;
  state_t               state;
  state_t               state_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic tc_c;
  logic clear_c;
  logic half_c;
  logic shift_c;
  logic load_c;
  logic ferr_c;

  serial_deserializer_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear_c),
    .half  (half_c),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!rx_s) state_next = ST_START;
      ST_START: if (tc_c) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tc_c && (bit_cnt == BIT_W'(DATA_BITS - 1))) state_next = ST_STOP;
      ST_STOP:  if (tc_c) state_next = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Counter is held cleared whenever no frame is being timed.
  always_comb begin
    clear_c = 1'b0;
    half_c  = 1'b0;
    shift_c = 1'b0;
    load_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state)
      ST_IDLE:  clear_c = 1'b1;
      ST_START: half_c  = 1'b1;
      ST_DATA:  shift_c = tc_c;
      ST_STOP: begin
        load_c = tc_c && rx_s;
        ferr_c = tc_c && !rx_s;
      end
      ST_BREAK: clear_c = 1'b1;
      default:  clear_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == ST_START) begin
        bit_cnt <= '0;
      end else if (shift_c) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (shift_c) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
    end
  end

  // A completed word always wins; an ack in the same cycle only suppresses overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data        <= '0;
      data_valid  <= 1'b0;
      all_ones    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_error <= ferr_c;
      busy        <= (state_next != ST_IDLE);
      if (load_c) begin
        data       <= shreg;
        all_ones   <= &shreg;
        data_valid <= 1'b1;
        if (data_valid && !data_ack) begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer with a word scoreboard and a status monitor.
module tb_serial_deserializer;

  localparam int unsigned CLKS = 16;
  localparam int unsigned DW   = 8;

  logic          clk;
  logic          reset;
  logic          rx;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          data_ack;
  logic          all_ones;
  logic          frame_error;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_count = 0;

  logic [DW:0] exp_q[$];

  serial_deserializer #(
    .DATA_BITS    (DW),
    .CLKS_PER_BIT (CLKS),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .all_ones    (all_ones),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    exp_q.push_back({&w, w});
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) drive_bit(w[i]);
    drive_bit(stop);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(posedge clk);
    #1;
    data_ack = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_valid"}, data_valid, 0);
    chk({tag, "_all_ones"}, all_ones, 0);
    chk({tag, "_frame_error"}, frame_error, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: pops the scoreboard whenever a new word is presented, and polices frame_error pulses.
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          fe_prev    = 1'b0;
  int            fe_w       = 0;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset) begin
      if (data_valid && (!prev_valid || data != prev_data)) begin
        chk("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("word_data", 32'(data), 32'(e[DW-1:0]));
          chk("word_all_ones", 32'(all_ones), 32'(e[DW]));
        end
      end
      if (frame_error && !fe_prev) fe_count++;
      if (frame_error) begin
        fe_w++;
      end else if (fe_prev) begin
        chk("frame_error_width", fe_w, 1);
        fe_w = 0;
      end
    end
    prev_valid = data_valid;
    prev_data  = data;
    fe_prev    = frame_error;
  end

  initial begin
    int t0;
    int lat;
    int fe0;
    logic [DW-1:0] w5a;

    reset    = 1'b1;
    rx       = 1'b1;
    data_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst");

    // Clean 0xA5, no ack: latency measured from the start edge.
    @(posedge clk); #1;
    push_word(8'hA5);
    fe0 = fe_count;
    t0  = cyc;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int n = 0; n < 300 && lat < 0; n++) begin
          @(negedge clk);
          if (data_valid) lat = cyc - t0;
        end
      end
    join
    chk("a5_valid", data_valid, 1);
    chk("a5_latency_window", 32'(lat >= 150 && lat <= 160), 1);
    chk("a5_no_frame_error", fe_count - fe0, 0);
    chk("a5_overrun", overrun, 0);
    ack_pulse();
    @(negedge clk);
    chk("a5_ack_clears", data_valid, 0);

    // 0xFF, ack three cycles after presentation.
    @(posedge clk); #1;
    push_word(8'hFF);
    send_frame(8'hFF, 1'b1);
    chk("ff_valid", data_valid, 1);
    chk("ff_all_ones", all_ones, 1);
    repeat (3) @(posedge clk);
    #1;
    ack_pulse();
    @(negedge clk);
    chk("ff_ack_clears", data_valid, 0);
    chk("ff_overrun", overrun, 0);

    // Five-cycle glitch on rx must be rejected.
    @(posedge clk); #1;
    fe0 = fe_count;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_rises", busy, 1);
    wait_idle("glitch_busy_drops", 10);
    chk("glitch_valid", data_valid, 0);
    chk("glitch_data", data, 8'hFF);
    chk("glitch_no_frame_error", fe_count - fe0, 0);

    // 0x3C with low stop bit followed by a held-low line.
    @(posedge clk); #1;
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    chk("break_one_frame_error", fe_count - fe0, 1);
    chk("break_valid", data_valid, 0);
    chk("break_busy", busy, 1);
    chk("break_data", data, 8'hFF);
    rx = 1'b1;
    wait_idle("break_busy_drops", 10);

    // Back-to-back 0x11, 0x22 without ack: overrun.
    @(posedge clk); #1;
    push_word(8'h11);
    push_word(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    chk("ovr_data", data, 8'h22);
    chk("ovr_valid", data_valid, 1);
    chk("ovr_set", overrun, 1);
    @(posedge clk); #1;
    ack_pulse();
    @(negedge clk);
    chk("ovr_ack_valid", data_valid, 0);
    chk("ovr_ack_clears", overrun, 0);

    // Same pair, ack exactly on the completion edge of 0x22.
    @(posedge clk); #1;
    push_word(8'h11);
    push_word(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
      end
    join
    @(negedge clk);
    chk("coack_data", data, 8'h22);
    chk("coack_valid", data_valid, 1);
    chk("coack_overrun", overrun, 0);
    @(posedge clk); #1;
    ack_pulse();

    // Reset in the middle of bit 4 of 0x5A, then a clean 0x81.
    @(posedge clk); #1;
    w5a = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(w5a[i]);
    rx = w5a[4];
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (20) @(posedge clk);
    #1;
    push_word(8'h81);
    send_frame(8'h81, 1'b1);
    chk("post_rst_valid", data_valid, 1);
    chk("post_rst_overrun", overrun, 0);
    ack_pulse();

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive side of the team's single-wire serial link.
- Samples one asynchronous serial line (8N1 framing: idle high, start bit low, LSB first, one stop bit high) and rebuilds a parallel word.
- Presents the word with a valid/ack handshake to downstream logic.
- Also reports word-level status: all-ones flag, framing error, overrun.

Parameters:
- DATA_BITS, 8: data bits per frame (range 5..16).
- CLKS_PER_BIT, 434: clk cycles per bit period (50 MHz / 115200). Must be >= 4.
- CNT_W, 16: width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- rx, input, 1: asynchronous serial line.
- data, output, DATA_BITS: last correctly framed word.
- data_valid, output, 1: data holds an unconsumed word.
- data_ack, input, 1: consumer takes the word this cycle.
- all_ones, output, 1: AND-reduction of data; valid only while data_valid=1.
- frame_error, output, 1: one-cycle pulse when the stop bit samples low.
- overrun, output, 1: sticky; a word was overwritten before ack.
- busy, output, 1: state is not IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - data=0, data_valid=0, all_ones=0, frame_error=0, overrun=0, busy=0.
  - Both rx synchroniser flops =1.
  - State=IDLE; bit counter=0; clock counter=0.
- Reset asserted mid-frame aborts the frame. The partial word is discarded and never appears on data.
- rx passes through a 2-flop synchroniser. All sampling below uses the synchronised value rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s=0, clear the clock counter and go to START.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division), then sample rx_s.
    - rx_s=1: glitch; return to IDLE with no output activity.
    - rx_s=0: clear the counter and go to DATA.
  - DATA: count to CLKS_PER_BIT-1, sample rx_s, and shift it into the shift register from the MSB side, so LSB-first bits land correctly.
    - After DATA_BITS samples, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - rx_s=1: load data from the shift register, set data_valid=1, go to IDLE.
    - rx_s=0: pulse frame_error for exactly one cycle, leave data/data_valid unchanged, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. A held-low line therefore produces only one frame_error.
- Latency: data_valid rises on the clk edge after the mid-stop-bit sample. That is about 9.5 bit periods plus 2 synchroniser cycles after the start edge on rx.
- Handshake:
  - data_valid stays high until a cycle with data_ack=1. It clears on that cycle's edge.
  - data_ack while data_valid=0 is ignored.
- Word completes while data_valid=1 and data_ack=0 that cycle:
  - data is overwritten and data_valid stays 1.
  - overrun is set and stays set until the next accepted ack.
- Word completes in the same cycle as data_ack=1:
  - the new word loads and data_valid stays 1.
  - overrun is unchanged.
- all_ones is registered alongside data: all_ones = &shift register at load time.
- No back-to-back gap is required: IDLE accepts a new start bit on the cycle after STOP completes.

Decomposition:
- Shared package/include holds:
  - FSM state encodings: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4, 3-bit.
  - Defaults for CLKS_PER_BIT and DATA_BITS.
- One natural sub-module, bit_timer: a CNT_W counter with clear input and terminal-count output (half or full period selected by a 1-bit input). It is reused later by the matching serializer.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8):
- Frame 0xA5 with correct stop bit, data_ack held 0 → data=0xA5, data_valid=1 about 152 cycles after the start edge, all_ones=0, frame_error=0.
- Frame 0xFF, ack 3 cycles after data_valid → data=0xFF, all_ones=1; data_valid drops on the edge after ack; overrun stays 0.
- rx low for 5 cycles only (glitch) → FSM returns to IDLE; data_valid, frame_error and data unchanged; busy drops within 10 cycles.
- Frame 0x3C with stop bit low, then line low for 100 cycles → one frame_error pulse of 1 cycle; data_valid stays 0; busy until rx returns high.
- Frames 0x11 then 0x22 with no ack → data=0x22, data_valid=1, overrun=1. Ack clears data_valid and overrun. Repeat with ack in the completion cycle of 0x22 → overrun stays 0.
- Reset pulse during bit 4 of frame 0x5A, then a clean frame 0x81 → all outputs at reset values; only 0x81 is reported.
